// File: rtl/digit_box_segmenter_if.sv
// Pixel-stream side of the digit segmenter: binarised pixels, frame sync and scan width.
interface digit_box_segmenter_if #(
    parameter int XW = 11
);
    logic          frame_vsync;
    logic          pix_de;
    logic          pix_bin;
    logic [XW-1:0] xpos;
    logic [XW-1:0] ypos;
    logic [XW-1:0] h_total;

    modport master (output frame_vsync, pix_de, pix_bin, xpos, ypos, h_total);
    modport slave  (input  frame_vsync, pix_de, pix_bin, xpos, ypos, h_total);
endinterface

// File: rtl/digit_box_segmenter.sv
// Frame-level digit segmenter: column-occupancy map built during the active frame,
// scanned in vertical blanking into left/right runs; top/bottom use last frame's boxes.
module digit_box_segmenter #(
    parameter int MAX_DIGIT   = 4,
    parameter int H_PIXEL_MAX = 800,
    parameter int XW          = 11,
    parameter int MIN_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    digit_box_segmenter_if.slave    pix,
    output logic [MAX_DIGIT*XW-1:0] box_left,
    output logic [MAX_DIGIT*XW-1:0] box_right,
    output logic [MAX_DIGIT*XW-1:0] box_top,
    output logic [MAX_DIGIT*XW-1:0] box_bottom,
    output logic [3:0]              digit_cnt,
    output logic                    box_valid,
    output logic                    overflow,
    output logic                    busy
);
    localparam logic [1:0]    ACCUM   = 2'd0;
    localparam logic [1:0]    SCAN    = 2'd1;
    localparam logic [1:0]    PUBLISH = 2'd2;
    localparam int            MW      = (H_PIXEL_MAX > 1) ? $clog2(H_PIXEL_MAX) : 1;
    localparam logic [XW:0]   HMAX    = (XW+1)'(H_PIXEL_MAX);
    localparam logic [XW:0]   MINW    = (XW+1)'(MIN_WIDTH);
    localparam logic [3:0]    MAXD    = 4'(MAX_DIGIT);
    localparam logic [XW-1:0] ONE     = XW'(1);
    localparam logic [XW:0]   ONE1    = (XW+1)'(1);

    logic [1:0]             state_q, state_d;
    logic                   vsync_q, vsync_d, rise_q, rise_d;
    logic [H_PIXEL_MAX-1:0] col_map_q, col_map_d;
    logic [XW-1:0]          h_lat_q, h_lat_d, x_q, x_d, run_start_q, run_start_d;
    logic                   run_on_q, run_on_d;
    logic [3:0]             cnt_q, cnt_d, prev_cnt_q, prev_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [XW-1:0]          left_q [MAX_DIGIT];
    logic [XW-1:0]          left_d [MAX_DIGIT];
    logic [XW-1:0]          right_q [MAX_DIGIT];
    logic [XW-1:0]          right_d [MAX_DIGIT];
    logic [XW-1:0]          prev_left_q [MAX_DIGIT];
    logic [XW-1:0]          prev_left_d [MAX_DIGIT];
    logic [XW-1:0]          prev_right_q [MAX_DIGIT];
    logic [XW-1:0]          prev_right_d [MAX_DIGIT];
    logic [XW-1:0]          top_q [MAX_DIGIT];
    logic [XW-1:0]          top_d [MAX_DIGIT];
    logic [XW-1:0]          bot_q [MAX_DIGIT];
    logic [XW-1:0]          bot_d [MAX_DIGIT];
    logic [MAX_DIGIT*XW-1:0] box_left_q, box_left_d, box_right_q, box_right_d;
    logic [MAX_DIGIT*XW-1:0] box_top_q, box_top_d, box_bottom_q, box_bottom_d;
    logic [3:0]             digit_cnt_q, digit_cnt_d;
    logic                   box_valid_q, box_valid_d, overflow_q, overflow_d;

    logic                   map_bit, run_close, slot_sel;
    logic [XW-1:0]          run_lo, run_hi, h_clamp;
    logic [XW:0]            run_w;

    always_comb begin
        state_d      = state_q;
        vsync_d      = pix.frame_vsync;
        rise_d       = pix.frame_vsync & ~vsync_q;
        col_map_d    = col_map_q;
        h_lat_d      = h_lat_q;
        x_d          = x_q;
        run_start_d  = run_start_q;
        run_on_d     = run_on_q;
        cnt_d        = cnt_q;
        prev_cnt_d   = prev_cnt_q;
        ovf_d        = ovf_q;
        left_d       = left_q;
        right_d      = right_q;
        prev_left_d  = prev_left_q;
        prev_right_d = prev_right_q;
        top_d        = top_q;
        bot_d        = bot_q;
        box_left_d   = box_left_q;
        box_right_d  = box_right_q;
        box_top_d    = box_top_q;
        box_bottom_d = box_bottom_q;
        digit_cnt_d  = digit_cnt_q;
        overflow_d   = overflow_q;
        box_valid_d  = 1'b0;
        map_bit      = 1'b0;
        run_close    = 1'b0;
        slot_sel     = 1'b0;
        run_lo       = '0;
        run_hi       = '0;
        run_w        = '0;
        h_clamp      = ({1'b0, pix.h_total} > HMAX) ? HMAX[XW-1:0] : pix.h_total;

        case (state_q)
            ACCUM: begin
                if (pix.pix_de && pix.pix_bin) begin
                    if ({1'b0, pix.xpos} < HMAX)
                        col_map_d[pix.xpos[MW-1:0]] = 1'b1;
                    for (int unsigned i = 0; i < MAX_DIGIT; i++) begin
                        if (4'(i) < prev_cnt_q && prev_left_q[i] <= pix.xpos &&
                            pix.xpos <= prev_right_q[i]) begin
                            if (pix.ypos < top_q[i]) top_d[i] = pix.ypos;
                            if (pix.ypos > bot_q[i]) bot_d[i] = pix.ypos;
                        end
                    end
                end
                if (rise_q) begin
                    h_lat_d  = h_clamp;
                    x_d      = '0;
                    run_on_d = 1'b0;
                    // An empty scan width still publishes, with no columns visited.
                    state_d  = (h_clamp == '0) ? PUBLISH : SCAN;
                end
            end
            SCAN: begin
                map_bit = col_map_q[x_q[MW-1:0]];
                col_map_d[x_q[MW-1:0]] = 1'b0;
                run_lo  = run_on_q ? run_start_q : x_q;
                if (map_bit && !run_on_q) run_start_d = x_q;
                if (!map_bit && run_on_q) begin
                    run_close = 1'b1;
                    run_hi    = x_q - ONE;
                end else if (map_bit && x_q == h_lat_q - ONE) begin
                    run_close = 1'b1;
                    run_hi    = x_q;
                end
                run_w = {1'b0, run_hi} - {1'b0, run_lo} + ONE1;
                if (run_close && run_w >= MINW) begin
                    if (cnt_q == MAXD) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < MAX_DIGIT; i++) begin
                            if (4'(i) == cnt_q) begin
                                left_d[i]  = run_lo;
                                right_d[i] = run_hi;
                            end
                        end
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                run_on_d = map_bit;
                x_d      = x_q + ONE;
                if (x_q == h_lat_q - ONE) state_d = PUBLISH;
            end
            PUBLISH: begin
                for (int unsigned i = 0; i < MAX_DIGIT; i++) begin
                    slot_sel = 4'(i) < cnt_q;
                    box_left_d[i*XW +: XW]  = slot_sel ? left_q[i]  : '0;
                    box_right_d[i*XW +: XW] = slot_sel ? right_q[i] : '0;
                    if (slot_sel && 4'(i) < prev_cnt_q && top_q[i] <= bot_q[i]) begin
                        box_top_d[i*XW +: XW]    = top_q[i];
                        box_bottom_d[i*XW +: XW] = bot_q[i];
                    end else begin
                        box_top_d[i*XW +: XW]    = '0;
                        box_bottom_d[i*XW +: XW] = '0;
                    end
                    prev_left_d[i]  = left_q[i];
                    prev_right_d[i] = right_q[i];
                    left_d[i]       = '0;
                    right_d[i]      = '0;
                    top_d[i]        = '1;
                    bot_d[i]        = '0;
                end
                digit_cnt_d = cnt_q;
                overflow_d  = ovf_q;
                box_valid_d = 1'b1;
                prev_cnt_d  = cnt_q;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                // Columns at or beyond the scanned width are dropped here in one go.
                col_map_d   = '0;
                state_d     = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            vsync_q      <= 1'b0;
            rise_q       <= 1'b0;
            col_map_q    <= '0;
            h_lat_q      <= '0;
            x_q          <= '0;
            run_start_q  <= '0;
            run_on_q     <= 1'b0;
            cnt_q        <= '0;
            prev_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            for (int unsigned i = 0; i < MAX_DIGIT; i++) begin
                left_q[i]       <= '0;
                right_q[i]      <= '0;
                prev_left_q[i]  <= '0;
                prev_right_q[i] <= '0;
                top_q[i]        <= '1;
                bot_q[i]        <= '0;
            end
            box_left_q   <= '0;
            box_right_q  <= '0;
            box_top_q    <= '0;
            box_bottom_q <= '0;
            digit_cnt_q  <= '0;
            box_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            rise_q       <= rise_d;
            col_map_q    <= col_map_d;
            h_lat_q      <= h_lat_d;
            x_q          <= x_d;
            run_start_q  <= run_start_d;
            run_on_q     <= run_on_d;
            cnt_q        <= cnt_d;
            prev_cnt_q   <= prev_cnt_d;
            ovf_q        <= ovf_d;
            left_q       <= left_d;
            right_q      <= right_d;
            prev_left_q  <= prev_left_d;
            prev_right_q <= prev_right_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            box_left_q   <= box_left_d;
            box_right_q  <= box_right_d;
            box_top_q    <= box_top_d;
            box_bottom_q <= box_bottom_d;
            digit_cnt_q  <= digit_cnt_d;
            box_valid_q  <= box_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign box_left   = box_left_q;
    assign box_right  = box_right_q;
    assign box_top    = box_top_q;
    assign box_bottom = box_bottom_q;
    assign digit_cnt  = digit_cnt_q;
    assign box_valid  = box_valid_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ACCUM);
endmodule

// File: tb/tb_digit_box_segmenter.sv
// Self-checking bench for digit_box_segmenter: directed and random frames against a
// frame-level model that finds runs in an occupancy array and tracks last frame's boxes.
module tb_digit_box_segmenter;
    localparam int MD = 4;
    localparam int HP = 800;
    localparam int XW = 11;
    localparam int MW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_box_segmenter_if #(.XW(XW)) pif ();
    logic [MD*XW-1:0] box_left, box_right, box_top, box_bottom;
    logic [3:0]       digit_cnt;
    logic             box_valid, overflow, busy;

    digit_box_segmenter #(
        .MAX_DIGIT(MD), .H_PIXEL_MAX(HP), .XW(XW), .MIN_WIDTH(MW)
    ) dut (
        .clk(clk), .rst(rst), .pix(pif),
        .box_left(box_left), .box_right(box_right),
        .box_top(box_top), .box_bottom(box_bottom),
        .digit_cnt(digit_cnt), .box_valid(box_valid),
        .overflow(overflow), .busy(busy)
    );

    int passed = 0;
    int total  = 0;

    int fx[$];
    int fy[$];
    int mp_l[MD];
    int mp_r[MD];
    int mp_cnt = 0;
    logic [MD*XW-1:0] e_l, e_r, e_t, e_b;
    int e_cnt;
    bit e_ovf;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame;
        fx.delete();
        fy.delete();
    endtask

    task automatic add_box(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                fx.push_back(x);
                fy.push_back(y);
            end
    endtask

    task automatic send_pixels;
        for (int k = 0; k < fx.size(); k++) begin
            if ($urandom_range(0, 3) == 0) begin
                pif.pix_de  = 1'b1;
                pif.pix_bin = 1'b0;
                pif.xpos    = XW'($urandom_range(0, HP - 1));
                pif.ypos    = XW'($urandom_range(0, 300));
                tick();
            end
            pif.pix_de  = 1'b1;
            pif.pix_bin = 1'b1;
            pif.xpos    = XW'(fx[k]);
            pif.ypos    = XW'(fy[k]);
            tick();
        end
        pif.pix_de  = 1'b0;
        pif.pix_bin = 1'b0;
        tick();
    endtask

    // Frame-level reference: occupancy array, maximal runs inside the scan width,
    // width filter, first MD kept; top/bottom from pixels inside last frame's boxes.
    task automatic model_frame(input int h);
        bit occ[HP];
        bit hit[MD];
        int tmin[MD];
        int tmax[MD];
        int nl[MD];
        int nr[MD];
        int n, x, s, hh;
        for (int i = 0; i < HP; i++) occ[i] = 1'b0;
        for (int i = 0; i < MD; i++) begin
            hit[i] = 1'b0; tmin[i] = 0; tmax[i] = 0; nl[i] = 0; nr[i] = 0;
        end
        for (int k = 0; k < fx.size(); k++) begin
            if (fx[k] < HP) occ[fx[k]] = 1'b1;
            for (int i = 0; i < mp_cnt; i++)
                if (fx[k] >= mp_l[i] && fx[k] <= mp_r[i]) begin
                    if (!hit[i] || fy[k] < tmin[i]) tmin[i] = fy[k];
                    if (!hit[i] || fy[k] > tmax[i]) tmax[i] = fy[k];
                    hit[i] = 1'b1;
                end
        end
        hh = (h > HP) ? HP : h;
        n = 0; x = 0; e_ovf = 1'b0;
        while (x < hh) begin
            if (occ[x]) begin
                s = x;
                while (x < hh && occ[x]) x++;
                if (x - s >= MW) begin
                    if (n < MD) begin
                        nl[n] = s; nr[n] = x - 1; n++;
                    end else e_ovf = 1'b1;
                end
            end else x++;
        end
        e_l = '0; e_r = '0; e_t = '0; e_b = '0;
        for (int i = 0; i < n; i++) begin
            e_l[i*XW +: XW] = XW'(nl[i]);
            e_r[i*XW +: XW] = XW'(nr[i]);
            if (i < mp_cnt && hit[i]) begin
                e_t[i*XW +: XW] = XW'(tmin[i]);
                e_b[i*XW +: XW] = XW'(tmax[i]);
            end
        end
        e_cnt = n;
        for (int i = 0; i < MD; i++) begin
            mp_l[i] = nl[i];
            mp_r[i] = nr[i];
        end
        mp_cnt = n;
    endtask

    task automatic run_frame(input string name, input int h, input bit disturb);
        int lat, pulses, hh;
        bit seen;
        hh = (h > HP) ? HP : h;
        send_pixels();
        model_frame(h);
        pif.h_total     = XW'(h);
        pif.frame_vsync = 1'b1;
        tick();
        lat = 0; seen = 1'b0;
        while (!seen && lat < hh + 20) begin
            if (disturb) begin
                if (lat == 1) pif.frame_vsync = 1'b0;
                if (lat == 3) pif.frame_vsync = 1'b1;
                if (lat >= 1 && lat < hh) begin
                    pif.pix_de  = 1'b1;
                    pif.pix_bin = 1'b1;
                    pif.xpos    = XW'($urandom_range(0, HP - 1));
                    pif.ypos    = XW'($urandom_range(0, 300));
                end else begin
                    pif.pix_de = 1'b0;
                end
            end
            tick();
            lat++;
            if (lat == 1) begin
                total++;
                if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, busy);
                else passed++;
            end
            seen = box_valid;
        end
        pif.pix_de = 1'b0;
        total++;
        if (!seen || lat != hh + 2)
            $display("FAIL %s latency: got %0d (seen=%0b) want %0d", name, lat, seen, hh + 2);
        else passed++;
        total++;
        if (digit_cnt !== 4'(e_cnt)) $display("FAIL %s digit_cnt: got %0d want %0d", name, digit_cnt, e_cnt);
        else passed++;
        total++;
        if (overflow !== e_ovf) $display("FAIL %s overflow: got %b want %b", name, overflow, e_ovf);
        else passed++;
        total++;
        if (box_left !== e_l) $display("FAIL %s box_left: got %h want %h", name, box_left, e_l);
        else passed++;
        total++;
        if (box_right !== e_r) $display("FAIL %s box_right: got %h want %h", name, box_right, e_r);
        else passed++;
        total++;
        if (box_top !== e_t) $display("FAIL %s box_top: got %h want %h", name, box_top, e_t);
        else passed++;
        total++;
        if (box_bottom !== e_b) $display("FAIL %s box_bottom: got %h want %h", name, box_bottom, e_b);
        else passed++;
        pif.frame_vsync = 1'b0;
        pulses = 0;
        for (int j = 0; j < hh + 6; j++) begin
            tick();
            if (box_valid) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL %s extra box_valid: got %0d want 0", name, pulses);
        else passed++;
        total++;
        if (box_left !== e_l || digit_cnt !== 4'(e_cnt) || busy !== 1'b0)
            $display("FAIL %s hold: got L=%h cnt=%0d busy=%b want L=%h cnt=%0d busy=0", name, box_left, digit_cnt, busy, e_l, e_cnt);
        else passed++;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (box_left !== '0 || box_right !== '0 || box_top !== '0 || box_bottom !== '0)
            $display("FAIL %s boxes: got %h %h %h %h want 0", name, box_left, box_right, box_top, box_bottom);
        else passed++;
        total++;
        if (digit_cnt !== 4'd0 || box_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s flags: got cnt=%0d valid=%b ovf=%b busy=%b want 0", name, digit_cnt, box_valid, overflow, busy);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        mp_cnt = 0;
    endtask

    task automatic test_two_digits;
        clear_frame();
        add_box(4, 9, 10, 30);
        add_box(20, 25, 10, 30);
        run_frame("two_digits_f1", 64, 1'b0);
        run_frame("two_digits_f2", 64, 1'b0);
    endtask

    task automatic test_narrow;
        clear_frame();
        add_box(40, 40, 5, 9);
        run_frame("narrow", 64, 1'b0);
    endtask

    task automatic test_overflow;
        clear_frame();
        for (int i = 0; i < 6; i++) add_box(2 + 6 * i, 4 + 6 * i, 3, 6);
        run_frame("overflow", 64, 1'b0);
    endtask

    task automatic test_right_edge;
        clear_frame();
        add_box(60, 63, 0, 3);
        add_box(100, 102, 7, 8);
        run_frame("right_edge", 64, 1'b0);
        clear_frame();
        run_frame("blank_after_edge", 128, 1'b0);
    endtask

    task automatic test_bounds;
        clear_frame();
        add_box(10, 14, 2, 4);
        run_frame("h_zero", 0, 1'b0);
        clear_frame();
        add_box(796, 799, 1, 2);
        fx.push_back(900);
        fy.push_back(5);
        run_frame("h_clamp", 1000, 1'b0);
    endtask

    task automatic test_reset_mid_scan;
        int pulses;
        clear_frame();
        add_box(4, 9, 10, 30);
        send_pixels();
        pif.h_total     = XW'(64);
        pif.frame_vsync = 1'b1;
        repeat (20) tick();
        pif.frame_vsync = 1'b0;
        rst = 1'b1;
        tick();
        check_zero("mid_scan_reset");
        rst = 1'b0;
        mp_cnt = 0;
        pulses = 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            if (box_valid) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL mid_scan_reset box_valid: got %0d want 0", pulses);
        else passed++;
        clear_frame();
        add_box(30, 33, 12, 14);
        run_frame("after_reset", 64, 1'b0);
    endtask

    task automatic test_scan_disturb;
        clear_frame();
        add_box(4, 9, 10, 30);
        add_box(20, 25, 10, 30);
        run_frame("disturb_f1", 64, 1'b0);
        run_frame("disturb_f2", 64, 1'b1);
        clear_frame();
        add_box(50, 52, 1, 1);
        run_frame("after_disturb", 64, 1'b0);
    endtask

    task automatic test_random;
        int h, x, w, y0;
        for (int f = 0; f < 6; f++) begin
            clear_frame();
            h = $urandom_range(30, 120);
            x = $urandom_range(0, 5);
            while (x < h + 20) begin
                w  = $urandom_range(1, 5);
                y0 = $urandom_range(0, 200);
                add_box(x, x + w - 1, y0, y0 + $urandom_range(0, 4));
                x = x + w + $urandom_range(1, 6);
            end
            if ($urandom_range(0, 1) == 1) begin
                fx.push_back(HP + 50);
                fy.push_back(9);
            end
            run_frame($sformatf("random_%0d", f), h, 1'b0);
        end
    endtask

    initial begin
        pif.frame_vsync = 1'b0;
        pif.pix_de      = 1'b0;
        pif.pix_bin     = 1'b0;
        pif.xpos        = '0;
        pif.ypos        = '0;
        pif.h_total     = '0;
        test_reset();
        test_two_digits();
        test_narrow();
        test_overflow();
        test_right_edge();
        test_bounds();
        test_reset_mid_scan();
        test_scan_disturb();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
